// File: rtl/seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit core; 2-5 cycles per instruction.
// Stall: en low freezes state/IR/retired and suppresses pc_store/reg_w/mem_w; rst aborts any instruction.
module seq_ctrl #(
    parameter int CNT_W = 16,
    parameter int IMM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [15:0]      instr,
    input  logic             rd1_zero,
    output logic             pc_store,
    output logic             pc_sel,
    output logic [15:0]      imm,
    output logic [1:0]       rn_1,
    output logic [1:0]       rn_2,
    output logic [1:0]       wn,
    output logic             reg_w,
    output logic [1:0]       wd_sel,
    output logic [1:0]       alu_op,
    output logic             mem_w,
    output logic             illegal,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_LDI  = 4'h5;
    localparam logic [3:0] OP_LD   = 4'h6;
    localparam logic [3:0] OP_ST   = 4'h7;
    localparam logic [3:0] OP_BEQZ = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           cur_st;
    state_t           nxt_st;
    logic [15:0]      ir;
    logic [CNT_W-1:0] ret_cnt;

    logic [3:0] op;
    logic [1:0] rd;
    logic [1:0] rs1;
    logic [1:0] rs2;
    logic       is_alu;
    logic       is_ill;
    logic       run;
    logic       retire;
    logic       pc_store_d;
    logic       reg_w_d;
    logic       mem_w_d;
    logic       illegal_d;

    assign op     = ir[15:12];
    assign rd     = ir[11:10];
    assign rs1    = ir[9:8];
    assign rs2    = ir[7:6];
    assign is_alu = (op >= 4'h1) && (op <= 4'h4);
    assign is_ill = (op >= 4'hA) && (op <= 4'hE);
    assign run    = en & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_st  <= FETCH;
            ir      <= '0;
            ret_cnt <= '0;
        end else if (en) begin
            cur_st <= nxt_st;
            if (cur_st == FETCH) begin
                ir <= instr;
            end
            if (retire) begin
                ret_cnt <= ret_cnt + CNT_ONE;
            end
        end
    end

    // retire marks the last cycle of each instruction; the counter only moves when en is high
    always_comb begin
        nxt_st     = cur_st;
        pc_store_d = 1'b0;
        pc_sel     = 1'b0;
        reg_w_d    = 1'b0;
        mem_w_d    = 1'b0;
        illegal_d  = 1'b0;
        retire     = 1'b0;
        case (cur_st)
            FETCH: begin
                pc_store_d = 1'b1;
                nxt_st     = DECODE;
            end
            DECODE: begin
                illegal_d = is_ill;
                if (is_alu || op == OP_LD || op == OP_ST || op == OP_BEQZ || op == OP_JMP) begin
                    nxt_st = EXEC;
                end else if (op == OP_LDI) begin
                    nxt_st = WB;
                end else if (op == OP_HLT) begin
                    nxt_st = HALT;
                    retire = 1'b1;
                end else begin
                    nxt_st = FETCH;
                    retire = 1'b1;
                end
            end
            EXEC: begin
                if (is_alu) begin
                    nxt_st = WB;
                end else if (op == OP_LD || op == OP_ST) begin
                    nxt_st = MEM;
                end else if (op == OP_JMP) begin
                    nxt_st     = FETCH;
                    pc_store_d = 1'b1;
                    pc_sel     = 1'b1;
                    retire     = 1'b1;
                end else begin
                    nxt_st     = FETCH;
                    pc_store_d = rd1_zero;
                    pc_sel     = rd1_zero;
                    retire     = 1'b1;
                end
            end
            MEM: begin
                if (op == OP_ST) begin
                    mem_w_d = 1'b1;
                    nxt_st  = FETCH;
                    retire  = 1'b1;
                end else begin
                    nxt_st = WB;
                end
            end
            WB: begin
                reg_w_d = 1'b1;
                nxt_st  = FETCH;
                retire  = 1'b1;
            end
            HALT: begin
                nxt_st = HALT;
            end
            default: begin
                nxt_st = FETCH;
            end
        endcase
    end

    // write strobes are qualified so a stall or reset can never commit state downstream
    assign pc_store = pc_store_d & run;
    assign reg_w    = reg_w_d & run;
    assign mem_w    = mem_w_d & run;
    assign illegal  = illegal_d & ~rst;
    assign halted   = (cur_st == HALT) & ~rst;

    assign rn_1    = (op == OP_BEQZ) ? rd : rs1;
    assign rn_2    = (op == OP_ST) ? rd : rs2;
    assign wn      = rd;
    assign alu_op  = is_alu ? (op[1:0] - 2'd1) : 2'd0;
    assign wd_sel  = (op == OP_LDI) ? 2'd1 : ((op == OP_LD) ? 2'd2 : 2'd0);
    assign imm     = {{(16-IMM_W){1'b0}}, ir[IMM_W-1:0]};
    assign state   = cur_st;
    assign retired = ret_cnt;

endmodule
